// File: rtl/bram_weight_reader.sv
// Burst read controller for the dual-port weight BRAM: even words on port A, odd on port B,
// with a two-stage tag pipeline steering the selected dout into a registered weight_out.
module bram_weight_reader #(
   parameter int MAC_NUM            = 256,
   parameter int BRAM_ADDRESS_WIDTH = 12
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [5*MAC_NUM-1:0]          weight_from_bram_A,
   input  logic [5*MAC_NUM-1:0]          weight_from_bram_B,
   output logic [5*MAC_NUM-1:0]          weight_out,
   output logic [BRAM_ADDRESS_WIDTH-1:0] bram_address_A,
   output logic [BRAM_ADDRESS_WIDTH-1:0] bram_address_B,
   output logic                          bram_A_en,
   output logic                          bram_B_en,
   input  logic                          address_reset,
   input  logic                          read_en,
   input  logic [BRAM_ADDRESS_WIDTH-1:0] read_length,
   output logic                          data_valid
);

   localparam int AW = BRAM_ADDRESS_WIDTH;

   typedef enum logic {IDLE, READ} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] len_q, len_d;
   logic [AW-1:0] k_q, k_d;
   logic          issue, issue_b;
   logic [AW-1:0] issue_addr;
   logic          tag1_v, tag1_b, tag2_v, tag2_b;

   // Word 0 is issued on the same edge that accepts read_en, so a 1-word burst never leaves IDLE.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      len_d      = len_q;
      k_d        = k_q;
      issue      = 1'b0;
      issue_b    = 1'b0;
      issue_addr = ptr_q;
      case (state_q)
         IDLE: begin
            if (address_reset) ptr_d = '0;
            if (read_en && read_length != '0) begin
               issue      = 1'b1;
               issue_addr = address_reset ? '0 : ptr_q;
               if (read_length == AW'(1)) begin
                  ptr_d = issue_addr + AW'(1);
               end else begin
                  state_d = READ;
                  ptr_d   = issue_addr;
                  len_d   = read_length;
                  k_d     = AW'(1);
               end
            end
         end
         READ: begin
            if (address_reset) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               issue      = 1'b1;
               issue_b    = k_q[0];
               issue_addr = ptr_q + k_q;
               if (k_q == len_q - AW'(1)) begin
                  state_d = IDLE;
                  ptr_d   = ptr_q + len_q;
               end else begin
                  k_d = k_q + AW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         ptr_q          <= '0;
         len_q          <= '0;
         k_q            <= '0;
         bram_A_en      <= 1'b0;
         bram_B_en      <= 1'b0;
         bram_address_A <= '0;
         bram_address_B <= '0;
         tag1_v         <= 1'b0;
         tag1_b         <= 1'b0;
         tag2_v         <= 1'b0;
         tag2_b         <= 1'b0;
         data_valid     <= 1'b0;
         weight_out     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         len_q     <= len_d;
         k_q       <= k_d;
         bram_A_en <= issue && !issue_b;
         bram_B_en <= issue && issue_b;
         if (issue && !issue_b) bram_address_A <= issue_addr;
         if (issue && issue_b)  bram_address_B <= issue_addr;
         tag1_v     <= issue;
         tag1_b     <= issue_b;
         tag2_v     <= tag1_v;
         tag2_b     <= tag1_b;
         data_valid <= tag2_v;
         if (tag2_v) weight_out <= tag2_b ? weight_from_bram_B : weight_from_bram_A;
      end
   end

endmodule

// File: tb/tb_bram_weight_reader.sv
// Directed bench for bram_weight_reader: BRAM model returns mem[i]=i on both ports,
// a monitor logs enables and valid words with cycle stamps, bursts are compared to hand-built sequences.
module tb_bram_weight_reader;

   localparam int MAC = 256;
   localparam int AW  = 12;
   localparam int WW  = 5 * MAC;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [WW-1:0] dout_a, dout_b, weight_out;
   logic [AW-1:0] bram_address_A, bram_address_B, read_length;
   logic          bram_A_en, bram_B_en, address_reset, read_en, data_valid;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int c0;

   int            en_cyc[$], en_port[$], en_addr[$], dv_cyc[$];
   logic [WW-1:0] dv_data[$];

   bram_weight_reader #(.MAC_NUM(MAC), .BRAM_ADDRESS_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .weight_from_bram_A(dout_a), .weight_from_bram_B(dout_b),
      .weight_out(weight_out),
      .bram_address_A(bram_address_A), .bram_address_B(bram_address_B),
      .bram_A_en(bram_A_en), .bram_B_en(bram_B_en),
      .address_reset(address_reset), .read_en(read_en),
      .read_length(read_length), .data_valid(data_valid)
   );

   always #5 clk = ~clk;

   initial begin
      dout_a = '0;
      dout_b = '0;
   end

   always @(posedge clk) begin
      if (bram_A_en) dout_a <= WW'(bram_address_A);
      if (bram_B_en) dout_b <= WW'(bram_address_B);
   end

   always @(posedge clk) begin
      #1;
      cyc++;
      if (bram_A_en) begin
         en_cyc.push_back(cyc); en_port.push_back(0); en_addr.push_back(int'(bram_address_A));
      end
      if (bram_B_en) begin
         en_cyc.push_back(cyc); en_port.push_back(1); en_addr.push_back(int'(bram_address_B));
      end
      if (data_valid) begin
         dv_cyc.push_back(cyc); dv_data.push_back(weight_out);
      end
   end

   task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      en_cyc.delete(); en_port.delete(); en_addr.delete();
      dv_cyc.delete(); dv_data.delete();
   endtask

   task automatic check_outputs_zero();
      check("rst_weight", weight_out, '0);
      check("rst_addr_a", WW'(bram_address_A), '0);
      check("rst_addr_b", WW'(bram_address_B), '0);
      check("rst_en_a", WW'(bram_A_en), '0);
      check("rst_en_b", WW'(bram_B_en), '0);
      check("rst_valid", WW'(data_valid), '0);
   endtask

   // Called right after a negedge; read_en is sampled first at the following posedge.
   task automatic start(input logic ar, input int len, input int hold, output int first);
      read_en       = 1'b1;
      read_length   = AW'(len);
      address_reset = ar;
      first         = cyc + 1;
      repeat (hold) @(negedge clk);
      read_en       = 1'b0;
      address_reset = 1'b0;
      read_length   = '0;
   endtask

   task automatic expect_seq(input int base, input int n, input int first);
      int m;
      check("en_count", WW'(en_addr.size()), WW'(n));
      check("dv_count", WW'(dv_data.size()), WW'(n));
      m = (en_addr.size() < n) ? en_addr.size() : n;
      for (int i = 0; i < m; i++) begin
         check("en_cycle", WW'(en_cyc[i]), WW'(first + i));
         check("en_port", WW'(en_port[i]), WW'(i % 2));
         check("en_addr", WW'(en_addr[i]), WW'((base + i) % 4096));
      end
      m = (dv_data.size() < n) ? dv_data.size() : n;
      for (int i = 0; i < m; i++) begin
         check("dv_cycle", WW'(dv_cyc[i]), WW'(first + 2 + i));
         check("dv_weight", dv_data[i], WW'((base + i) % 4096));
      end
      if (n > 0) check("weight_hold", weight_out, WW'((base + n - 1) % 4096));
      clear_logs();
   endtask

   initial begin
      rst_n         = 1'b0;
      read_en       = 1'b0;
      address_reset = 1'b0;
      read_length   = '0;
      repeat (2) @(negedge clk);
      check_outputs_zero();
      rst_n = 1'b1;
      @(negedge clk);
      clear_logs();

      // single word from address 0 with address_reset and read_en together
      start(1'b1, 1, 1, c0);
      repeat (6) @(negedge clk);
      expect_seq(0, 1, c0);

      start(1'b1, 4, 1, c0);
      repeat (8) @(negedge clk);
      expect_seq(0, 4, c0);

      start(1'b0, 2, 1, c0);
      repeat (6) @(negedge clk);
      expect_seq(4, 2, c0);

      // long burst to park the pointer at 4094
      start(1'b1, 4094, 1, c0);
      repeat (4100) @(negedge clk);
      expect_seq(0, 4094, c0);

      start(1'b0, 3, 1, c0);
      repeat (7) @(negedge clk);
      expect_seq(4094, 3, c0);

      // zero length is a no-op; pointer is now 1
      start(1'b0, 0, 1, c0);
      repeat (5) @(negedge clk);
      expect_seq(1, 0, c0);

      // read_en pulse with another length during READ is ignored
      start(1'b0, 4, 1, c0);
      @(negedge clk);
      read_en     = 1'b1;
      read_length = AW'(7);
      @(negedge clk);
      read_en     = 1'b0;
      read_length = '0;
      repeat (8) @(negedge clk);
      expect_seq(1, 4, c0);

      // back-to-back: read_en still high when the first 2-word burst re-enters IDLE
      start(1'b0, 2, 3, c0);
      repeat (8) @(negedge clk);
      expect_seq(5, 4, c0);

      // abort at word 2 of 8: two words drain, pointer returns to 0
      start(1'b0, 8, 1, c0);
      @(negedge clk);
      address_reset = 1'b1;
      @(negedge clk);
      address_reset = 1'b0;
      repeat (8) @(negedge clk);
      expect_seq(9, 2, c0);

      start(1'b0, 1, 1, c0);
      repeat (6) @(negedge clk);
      expect_seq(0, 1, c0);

      // mid-idle reset pulse clears outputs and pointer
      start(1'b0, 2, 1, c0);
      repeat (6) @(negedge clk);
      expect_seq(1, 2, c0);
      rst_n = 1'b0;
      @(negedge clk);
      check_outputs_zero();
      rst_n = 1'b1;
      @(negedge clk);
      clear_logs();
      start(1'b0, 1, 1, c0);
      repeat (6) @(negedge clk);
      expect_seq(0, 1, c0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
